// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM encoding,
// default geometry and tag-width derivation.
package cache_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 2;
  localparam int LINES      = 1 << DEF_IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic int tag_width(input int addr_w, input int idx_w);
    return addr_w - idx_w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side request/response and memory-port signals of the cache controller.
interface cache_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              read_operation;
  logic              cache_busy;
  logic              bus_busy;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [7:0]        hit_count;
  logic [7:0]        miss_count;

  modport slave (
    input  start, address, data, read_operation, mem_rdata, mem_ack,
    output cache_busy, bus_busy, read_data, read_valid,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output start, address, data, read_operation, mem_rdata, mem_ack,
    input  cache_busy, bus_busy, read_data, read_valid,
           mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_tag_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational lookup,
// one synchronous write port, valid bits cleared on reset.
module cache_tag_array
  import cache_ctrl_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = 6,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_valid,
  output logic [TAG_W-1:0]  lk_tag,
  output logic [DATA_W-1:0] lk_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int N_LINES = 1 << IDX_W;

  logic [N_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_mem  [N_LINES];
  logic [DATA_W-1:0]  data_mem [N_LINES];

  generate
    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Contents only matter behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign lk_valid = valid_reg[lk_idx];
  assign lk_tag   = tag_mem[lk_idx];
  assign lk_data  = data_mem[lk_idx];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// single-outstanding memory port and saturating hit/miss counters.
module cache_ctrl_dm
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.slave bus
);
  localparam int TAG_W = tag_width(ADDR_W, IDX_W);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rd_reg;
  logic [DATA_W-1:0] read_data_reg;
  logic [7:0]        hit_cnt_reg;
  logic [7:0]        miss_cnt_reg;

  logic              lk_valid;
  logic [TAG_W-1:0]  lk_tag;
  logic [DATA_W-1:0] lk_data;
  logic              hit;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  cache_tag_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .lk_idx  (addr_reg[IDX_W-1:0]),
    .lk_valid(lk_valid),
    .lk_tag  (lk_tag),
    .lk_data (lk_data),
    .wr_en   (wr_en),
    .wr_idx  (addr_reg[IDX_W-1:0]),
    .wr_tag  (addr_reg[ADDR_W-1:IDX_W]),
    .wr_data (wr_data)
  );

  assign hit = lk_valid && (lk_tag == addr_reg[ADDR_W-1:IDX_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (!rd_reg)  state_next = ST_MEM_WR;
        else if (hit) state_next = ST_RESP;
        else          state_next = ST_MEM_RD;
      end
      ST_MEM_RD: if (bus.mem_ack) state_next = ST_RESP;
      ST_MEM_WR: if (bus.mem_ack) state_next = ST_IDLE;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Every handshake output is a pure decode of the state register.
  always_comb begin
    bus.cache_busy = (state_reg != ST_IDLE);
    bus.bus_busy   = (state_reg == ST_MEM_RD) || (state_reg == ST_MEM_WR);
    bus.mem_req    = (state_reg == ST_MEM_RD) || (state_reg == ST_MEM_WR);
    bus.mem_we     = (state_reg == ST_MEM_WR);
    bus.read_valid = (state_reg == ST_RESP);
    wr_en          = ((state_reg == ST_LOOKUP) && !rd_reg && hit)
                  || ((state_reg == ST_MEM_RD) && bus.mem_ack);
    wr_data        = (state_reg == ST_MEM_RD) ? bus.mem_rdata : data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      data_reg      <= '0;
      rd_reg        <= 1'b0;
      read_data_reg <= '0;
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && bus.start) begin
        addr_reg <= bus.address;
        data_reg <= bus.data;
        rd_reg   <= bus.read_operation;
      end
      if (state_reg == ST_LOOKUP) begin
        if (hit) begin
          hit_cnt_reg <= sat_inc(hit_cnt_reg);
          if (rd_reg) read_data_reg <= lk_data;
        end else begin
          miss_cnt_reg <= sat_inc(miss_cnt_reg);
        end
      end
      if ((state_reg == ST_MEM_RD) && bus.mem_ack) begin
        read_data_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = data_reg;
  assign bus.read_data  = read_data_reg;
  assign bus.hit_count  = hit_cnt_reg;
  assign bus.miss_count = miss_cnt_reg;

endmodule
